// File: rtl/tl_ul_channel_buffer_if.sv
// TileLink-UL channel bundle around the buffer. The slave modport is the buffer's view
// (accepts A from the master side, issues D to it); the master modport is the view of the
// environment driving both the master port and the slave-side fabric.
interface tl_ul_channel_buffer_if #(
  parameter int unsigned SRC_W  = 2,
  parameter int unsigned ADDR_W = 31
);
  // Master-side A channel
  logic              auto_in_a_valid;
  logic              auto_in_a_ready;
  logic [2:0]        auto_in_a_opcode;
  logic [2:0]        auto_in_a_param;
  logic [2:0]        auto_in_a_size;
  logic [SRC_W-1:0]  auto_in_a_source;
  logic [ADDR_W-1:0] auto_in_a_address;
  logic [3:0]        auto_in_a_mask;
  logic [31:0]       auto_in_a_data;
  // Slave-side A channel
  logic              auto_out_a_valid;
  logic              auto_out_a_ready;
  logic [2:0]        auto_out_a_opcode;
  logic [2:0]        auto_out_a_param;
  logic [2:0]        auto_out_a_size;
  logic [SRC_W-1:0]  auto_out_a_source;
  logic [ADDR_W-1:0] auto_out_a_address;
  logic [3:0]        auto_out_a_mask;
  logic [31:0]       auto_out_a_data;
  // Slave-side D channel
  logic              auto_out_d_valid;
  logic              auto_out_d_ready;
  logic [2:0]        auto_out_d_opcode;
  logic [1:0]        auto_out_d_param;
  logic [2:0]        auto_out_d_size;
  logic [SRC_W-1:0]  auto_out_d_source;
  logic              auto_out_d_denied;
  logic              auto_out_d_corrupt;
  logic [31:0]       auto_out_d_data;
  // Master-side D channel
  logic              auto_in_d_valid;
  logic              auto_in_d_ready;
  logic [2:0]        auto_in_d_opcode;
  logic [1:0]        auto_in_d_param;
  logic [2:0]        auto_in_d_size;
  logic [SRC_W-1:0]  auto_in_d_source;
  logic              auto_in_d_denied;
  logic              auto_in_d_corrupt;
  logic [31:0]       auto_in_d_data;

  modport slave (
    input  auto_in_a_valid, auto_in_a_opcode, auto_in_a_param, auto_in_a_size,
           auto_in_a_source, auto_in_a_address, auto_in_a_mask, auto_in_a_data,
    output auto_in_a_ready,
    output auto_out_a_valid, auto_out_a_opcode, auto_out_a_param, auto_out_a_size,
           auto_out_a_source, auto_out_a_address, auto_out_a_mask, auto_out_a_data,
    input  auto_out_a_ready,
    input  auto_out_d_valid, auto_out_d_opcode, auto_out_d_param, auto_out_d_size,
           auto_out_d_source, auto_out_d_denied, auto_out_d_corrupt, auto_out_d_data,
    output auto_out_d_ready,
    output auto_in_d_valid, auto_in_d_opcode, auto_in_d_param, auto_in_d_size,
           auto_in_d_source, auto_in_d_denied, auto_in_d_corrupt, auto_in_d_data,
    input  auto_in_d_ready
  );

  modport master (
    output auto_in_a_valid, auto_in_a_opcode, auto_in_a_param, auto_in_a_size,
           auto_in_a_source, auto_in_a_address, auto_in_a_mask, auto_in_a_data,
    input  auto_in_a_ready,
    input  auto_out_a_valid, auto_out_a_opcode, auto_out_a_param, auto_out_a_size,
           auto_out_a_source, auto_out_a_address, auto_out_a_mask, auto_out_a_data,
    output auto_out_a_ready,
    output auto_out_d_valid, auto_out_d_opcode, auto_out_d_param, auto_out_d_size,
           auto_out_d_source, auto_out_d_denied, auto_out_d_corrupt, auto_out_d_data,
    input  auto_out_d_ready,
    input  auto_in_d_valid, auto_in_d_opcode, auto_in_d_param, auto_in_d_size,
           auto_in_d_source, auto_in_d_denied, auto_in_d_corrupt, auto_in_d_data,
    output auto_in_d_ready
  );
endinterface

// File: rtl/tl_ul_channel_buffer.sv
// Registered TileLink-UL A/D buffer: one FIFO per channel, outstanding-request counter with
// a throttle limit, and a sticky flag for responses that arrive with nothing outstanding.
module tl_ul_channel_buffer #(
  parameter int unsigned DEPTH        = 2,
  parameter int unsigned SRC_W        = 2,
  parameter int unsigned ADDR_W       = 31,
  parameter int unsigned MAX_INFLIGHT = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  tl_ul_channel_buffer_if.slave  bus,
  output logic [3:0]             inflight,
  output logic                   protocol_err
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned AW   = 3 + 3 + 3 + SRC_W + ADDR_W + 4 + 32;
  localparam int unsigned DW   = 3 + 2 + 3 + SRC_W + 1 + 1 + 32;

  localparam logic [CntW-1:0] DepthCnt    = CntW'(DEPTH);
  localparam logic [3:0]      MaxInflight = 4'(MAX_INFLIGHT);

  logic [AW-1:0]   a_mem_q [DEPTH];
  logic [AW-1:0]   a_mem_d [DEPTH];
  logic [PtrW-1:0] a_wptr_q, a_wptr_d, a_rptr_q, a_rptr_d;
  logic [CntW-1:0] a_cnt_q, a_cnt_d;

  logic [DW-1:0]   d_mem_q [DEPTH];
  logic [DW-1:0]   d_mem_d [DEPTH];
  logic [PtrW-1:0] d_wptr_q, d_wptr_d, d_rptr_q, d_rptr_d;
  logic [CntW-1:0] d_cnt_q, d_cnt_d;

  logic [3:0] inflight_q, inflight_d;
  logic       protocol_err_q, protocol_err_d;

  logic a_push, a_pop, d_push, d_pop;
  logic [AW-1:0] a_wdata;
  logic [DW-1:0] d_wdata;

  // Handshakes: readies and valids depend only on registered state, never on a valid input
  always_comb begin
    bus.auto_in_a_ready  = (a_cnt_q != DepthCnt) && (inflight_q < MaxInflight);
    bus.auto_out_a_valid = (a_cnt_q != '0);
    bus.auto_out_d_ready = (d_cnt_q != DepthCnt);
    bus.auto_in_d_valid  = (d_cnt_q != '0);
    a_push = bus.auto_in_a_valid && bus.auto_in_a_ready;
    a_pop  = bus.auto_out_a_valid && bus.auto_out_a_ready;
    d_push = bus.auto_out_d_valid && bus.auto_out_d_ready;
    d_pop  = bus.auto_in_d_valid && bus.auto_in_d_ready;
    a_wdata = {bus.auto_in_a_opcode, bus.auto_in_a_param, bus.auto_in_a_size,
               bus.auto_in_a_source, bus.auto_in_a_address, bus.auto_in_a_mask,
               bus.auto_in_a_data};
    d_wdata = {bus.auto_out_d_opcode, bus.auto_out_d_param, bus.auto_out_d_size,
               bus.auto_out_d_source, bus.auto_out_d_denied, bus.auto_out_d_corrupt,
               bus.auto_out_d_data};
  end

  // Output fields always come from the head entry of each FIFO
  always_comb begin
    {bus.auto_out_a_opcode, bus.auto_out_a_param, bus.auto_out_a_size,
     bus.auto_out_a_source, bus.auto_out_a_address, bus.auto_out_a_mask,
     bus.auto_out_a_data} = a_mem_q[a_rptr_q];
    {bus.auto_in_d_opcode, bus.auto_in_d_param, bus.auto_in_d_size,
     bus.auto_in_d_source, bus.auto_in_d_denied, bus.auto_in_d_corrupt,
     bus.auto_in_d_data} = d_mem_q[d_rptr_q];
  end

  // A FIFO next state; pointers wrap naturally since DEPTH is a power of two
  always_comb begin
    a_mem_d  = a_mem_q;
    a_wptr_d = a_wptr_q;
    a_rptr_d = a_rptr_q;
    a_cnt_d  = a_cnt_q;
    if (a_push) begin
      a_mem_d[a_wptr_q] = a_wdata;
      a_wptr_d          = a_wptr_q + 1'b1;
    end
    if (a_pop) a_rptr_d = a_rptr_q + 1'b1;
    if (a_push && !a_pop)      a_cnt_d = a_cnt_q + 1'b1;
    else if (!a_push && a_pop) a_cnt_d = a_cnt_q - 1'b1;
  end

  // D FIFO next state
  always_comb begin
    d_mem_d  = d_mem_q;
    d_wptr_d = d_wptr_q;
    d_rptr_d = d_rptr_q;
    d_cnt_d  = d_cnt_q;
    if (d_push) begin
      d_mem_d[d_wptr_q] = d_wdata;
      d_wptr_d          = d_wptr_q + 1'b1;
    end
    if (d_pop) d_rptr_d = d_rptr_q + 1'b1;
    if (d_push && !d_pop)      d_cnt_d = d_cnt_q + 1'b1;
    else if (!d_push && d_pop) d_cnt_d = d_cnt_q - 1'b1;
  end

  // Outstanding count; a response with nothing outstanding saturates at 0 and latches the error
  always_comb begin
    inflight_d     = inflight_q;
    protocol_err_d = protocol_err_q;
    if (a_push && !d_pop) begin
      inflight_d = inflight_q + 1'b1;
    end else if (!a_push && d_pop) begin
      if (inflight_q == '0) protocol_err_d = 1'b1;
      else                  inflight_d     = inflight_q - 1'b1;
    end
  end

  // State registers; storage is cleared so heads never show X
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        a_mem_q[i] <= '0;
        d_mem_q[i] <= '0;
      end
      a_wptr_q       <= '0;
      a_rptr_q       <= '0;
      a_cnt_q        <= '0;
      d_wptr_q       <= '0;
      d_rptr_q       <= '0;
      d_cnt_q        <= '0;
      inflight_q     <= '0;
      protocol_err_q <= 1'b0;
    end else begin
      a_mem_q        <= a_mem_d;
      d_mem_q        <= d_mem_d;
      a_wptr_q       <= a_wptr_d;
      a_rptr_q       <= a_rptr_d;
      a_cnt_q        <= a_cnt_d;
      d_wptr_q       <= d_wptr_d;
      d_rptr_q       <= d_rptr_d;
      d_cnt_q        <= d_cnt_d;
      inflight_q     <= inflight_d;
      protocol_err_q <= protocol_err_d;
    end
  end

  assign inflight     = inflight_q;
  assign protocol_err = protocol_err_q;

endmodule
